// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: frame size, address/pixel widths and per-buffer state type
package frame_buf_pkg;
    localparam int FRAME_PIXELS = 10000;
    localparam int ADDR_W = 20;
    localparam int PIX_W = 24;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} buf_state_e;
endpackage

// File: rtl/frame_buf_ctrl_slot_state.sv
// fb_slot_state: EMPTY/FILLING/FULL/DRAINING tracker for one frame buffer
module fb_slot_state
    import frame_buf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_fire_i,
    input  logic       wr_last_i,
    input  logic       rd_fire_i,
    input  logic       rd_last_i,
    output buf_state_e state_o
);
    buf_state_e state_q, state_d;
    // a slot is never written and read in the same cycle, so the two updates never collide
    always_comb begin
        state_d = wr_fire_i ? (wr_last_i ? FULL : FILLING) :
                  rd_fire_i ? (rd_last_i ? EMPTY : DRAINING) : state_q;
    end
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end
    assign state_o = state_q;
endmodule

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: ping-pong frame buffer controller; define FRAME_REPEAT_EN to replay the current frame on underrun
module frame_buf_ctrl
    import frame_buf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [PIX_W-1:0]  rd_data1,
    input  logic [PIX_W-1:0]  rd_data2,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    output logic              WE1,
    output logic              RE1,
    output logic              Buf1Empty,
    output logic [ADDR_W-1:0] Addr1,
    output logic              WE2,
    output logic              RE2,
    output logic              Buf2Empty,
    output logic [ADDR_W-1:0] Addr2,
    output logic [31:0]       WData
);
    logic                   run_q, wsel_q, wsel_d, rsel_q, rsel_d, pv_q, psel_q;
    logic [ADDR_W-1:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]             we_q, we_d, re_q, re_d, writable;
    logic [31:0]            wdata_q, wdata_d;
    logic                   wr_acc, rd_acc, wr_last, rd_last, rd_swap;
    buf_state_e             st [2];

    for (genvar i = 0; i < 2; i++) begin : g_slot
        fb_slot_state u_slot (
            .clk       (clk),
            .reset     (reset),
            .wr_fire_i (we_d[i]),
            .wr_last_i (wr_last),
            .rd_fire_i (re_d[i]),
            .rd_last_i (rd_swap),
            .state_o   (st[i])
        );
        assign writable[i] = (st[i] == EMPTY) || (st[i] == FILLING);
    end

    // run_q holds the ready outputs low until the first edge after reset release
    assign wr_ready = run_q & writable[wsel_q];
    assign rd_ready = run_q & ~writable[rsel_q];
    assign wr_acc   = wr_valid & wr_ready;
    assign rd_acc   = rd_req & rd_ready;
    assign wr_last  = wcnt_q == LAST_ADDR;
    assign rd_last  = rcnt_q == LAST_ADDR;
    assign we_d     = wr_acc ? (wsel_q ? 2'b10 : 2'b01) : 2'b00;
    assign re_d     = rd_acc ? (rsel_q ? 2'b10 : 2'b01) : 2'b00;
`ifdef FRAME_REPEAT_EN
    // replay this buffer at frame end unless the other one is full or completing its last write now
    assign rd_swap  = rd_last & ((st[~rsel_q] == FULL) | (we_d[~rsel_q] & wr_last));
`else
    assign rd_swap  = rd_last;
`endif

    // next-state for counters, buffer selects and the buffer-side command registers
    always_comb begin
        wcnt_d  = wr_acc ? (wr_last ? '0 : wcnt_q + 1'b1) : wcnt_q;
        rcnt_d  = rd_acc ? (rd_last ? '0 : rcnt_q + 1'b1) : rcnt_q;
        wsel_d  = wsel_q ^ (wr_acc & wr_last);
        rsel_d  = rsel_q ^ (rd_acc & rd_swap);
        wdata_d = wr_acc ? wr_data : wdata_q;
        for (int b = 0; b < 2; b++)
            addr_d[b] = we_d[b] ? wcnt_q : re_d[b] ? rcnt_q : addr_q[b];
    end

    // registers; the pv/psel stage covers the buffer's one-cycle registered read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q   <= 1'b0;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            we_q    <= '0;
            re_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pv_q    <= 1'b0;
            psel_q  <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            we_q    <= we_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pv_q    <= |re_q;
            psel_q  <= re_q[1];
        end
    end

    assign WE1       = we_q[0];
    assign WE2       = we_q[1];
    assign RE1       = re_q[0];
    assign RE2       = re_q[1];
    assign Addr1     = addr_q[0];
    assign Addr2     = addr_q[1];
    assign WData     = wdata_q;
    assign Buf1Empty = writable[0];
    assign Buf2Empty = writable[1];
    assign pix_valid = pv_q;
    assign pix_out   = pv_q ? (psel_q ? rd_data2 : rd_data1) : '0;
endmodule

// File: doc/frame_buf_ctrl.md
FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port wr_valid, input, 1: the source offers the pixel on wr_data.
REQ-004 SHALL have port wr_data, input, 32: pixel word; bits [23:0] = {B,G,R}.
REQ-005 SHALL have port wr_ready, output, 1: the controller accepts the write this cycle.
REQ-006 SHALL have port rd_req, input, 1: the display requests the next pixel.
REQ-007 SHALL have port rd_ready, output, 1: the controller accepts rd_req this cycle.
REQ-008 SHALL have ports rd_data1 and rd_data2, input, 24 each: registered {B,G,R} outputs of buffer 1 and buffer 2.
REQ-009 SHALL have port pix_out, output, 24: pixel returned to the display.
REQ-010 SHALL have port pix_valid, output, 1: pix_out is valid.
REQ-011 SHALL have ports WE1, RE1, Buf1Empty, output, 1 each, and Addr1, output, 20: buffer 1 control.
REQ-012 SHALL have ports WE2, RE2, Buf2Empty, output, 1 each, and Addr2, output, 20: buffer 2 control.
REQ-013 SHALL have port WData, output, 32: registered copy of the accepted wr_data.

Function
REQ-014 SHALL track each buffer in state EMPTY, FILLING, FULL or DRAINING; wsel and rsel (1 bit each) select the buffer currently written and currently read.
REQ-015 SHALL assert wr_ready only while buffer[wsel] is EMPTY or FILLING; a write is accepted when wr_valid and wr_ready are both 1.
REQ-016 SHALL, on the edge after an accepted write, drive WEx=1, Addrx=wcnt and WData=wr_data to buffer[wsel]; wcnt runs 0..9999; the first accepted write moves EMPTY to FILLING.
REQ-017 SHALL, when the write at wcnt=9999 is accepted, mark the buffer FULL, clear wcnt to 0 and toggle wsel; if the other buffer is not EMPTY, wr_ready stays 0 until it becomes EMPTY.
REQ-018 SHALL drive BufxEmpty=1 iff buffer x is EMPTY or FILLING.
REQ-019 SHALL assert rd_ready only while buffer[rsel] is FULL or DRAINING; an accepted rd_req drives REx=1, Addrx=rcnt on the next edge; the first accepted read moves FULL to DRAINING.
REQ-020 SHALL assert pix_valid exactly 2 cycles after rd_req is accepted (1 cycle for RE/Addr, 1 cycle for the buffer read), with pix_out = rd_data of the buffer that was read; one pix_valid per accepted request, in order.
REQ-021 SHALL, when the read at rcnt=9999 is accepted, mark the buffer EMPTY, clear rcnt to 0 and toggle rsel.
REQ-022 SHALL apply write-completion and read-completion in the same cycle independently; a buffer that just became FULL is readable from the following cycle.
REQ-023 SHALL hold WEx and REx low when they are not commanded; WE and RE are never both 1 for the same buffer in one cycle (guaranteed by the state rules).
REQ-024 SHALL deassert rd_ready when neither buffer is readable (underrun); pix_valid stays 0 and nothing is dropped.

Reset
REQ-025 SHALL, while reset=0, immediately force both buffers to EMPTY, wsel=rsel=0, wcnt=rcnt=0, all WE/RE=0, Addr1=Addr2=0, WData=0, pix_out=0, pix_valid=0, wr_ready=0, rd_ready=0 and Buf1Empty=Buf2Empty=1.
REQ-026 SHALL raise wr_ready on the first edge after reset release; reads in flight when reset is asserted are discarded.

Configuration
REQ-027 SHALL, with FRAME_REPEAT_EN defined, handle a read of rcnt=9999 when the other buffer is not FULL by restarting rcnt at 0 on the same buffer, which stays DRAINING, so the frame repeats; the swap happens at the next frame end at which the other buffer is FULL.
REQ-028 SHALL, without FRAME_REPEAT_EN, follow REQ-021 and REQ-024 (stall on underrun).

Structure
REQ-029 SHALL place FRAME_PIXELS=10000, ADDR_W=20, PIX_W=24 and the buffer-state enum in package frame_buf_pkg.
REQ-030 SHALL implement per-buffer state tracking as sub-module fb_slot_state, instantiated twice.

Verification
REQ-031 Test: release reset, write 10000 pixels with value equal to the index -> Addr1 sweeps 0..9999, Buf1 goes FULL, wsel=1, Buf2Empty=1.
REQ-032 Test: after REQ-031, issue 10000 rd_req -> pix_out[i]=i[23:0] with 2-cycle latency, then Buf1Empty=1 and rsel=1.
REQ-033 Test: fill both buffers with no reads -> wr_ready=0 on the 20001st offer; first read completion of buffer 1 restores wr_ready.
REQ-034 Test: last write of buffer 2 and last read of buffer 1 in the same cycle -> buffer 1 EMPTY, buffer 2 FULL, rd_ready=1 the next cycle.
REQ-035 Test: reset=0 mid-frame at wcnt=500 and rcnt=300 -> all outputs take their REQ-025 values with no clock edge.
REQ-036 Test: with FRAME_REPEAT_EN, read a frame while the other buffer is not filled -> Addr wraps 9999->0 on the same buffer and rd_ready stays 1; without the macro -> rd_ready=0.
